// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV base-ISA opcodes, immediate format codes and helpers
package rv_isa_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

  function automatic logic xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic logic opc_supported(input logic [6:0] opc);
    return (opc == OPC_LOAD)  || (opc == OPC_OPIMM) || (opc == OPC_STORE) ||
           (opc == OPC_BRANCH) || (opc == OPC_LUI)  || (opc == OPC_AUIPC) ||
           (opc == OPC_JAL)   || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// rtl/imm_gen_comb.sv - combinational instruction word to immediate/format decoder
module imm_gen_comb
  import rv_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
      end
      OPC_OPIMM: begin
        // shift-immediates carry an unsigned shamt; funct7 is not part of it
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
          fmt   = FMT_SHAMT;
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
          fmt   = FMT_I;
        end
      end
      OPC_STORE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OPC_JAL: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      default: illegal = 1'b1;
    endcase
  end

  // bit 31 of imm32 is already the correct extension bit for every format
  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV immediate generator with valid/ready and illegal counter
module imm_gen_pipe
  import rv_isa_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic            src_valid;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  imm_fmt_t        fmt_q;
  logic            out_load;
  logic            in_fire;

  assign out_load = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fmt  = fmt_q;

  generate
    if (!xlen_ok(XLEN)) begin : g_xlen_check
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    if (STAGES >= 2) begin : g_in_stage
      logic        s1_valid;
      logic [31:0] s1_instr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_instr <= '0;
        end else if (flush) begin
          s1_valid <= 1'b0;
        end else if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) s1_instr <= in_instr;
        end
      end

      // stage 1 frees up whenever the output register can take its word
      assign in_ready  = !s1_valid || out_load;
      assign src_valid = s1_valid;
      assign src_instr = s1_instr;
    end else begin : g_no_in_stage
      assign in_ready  = out_load;
      assign src_valid = in_valid;
      assign src_instr = in_instr;
    end
  endgenerate

  imm_gen_comb #(
    .XLEN (XLEN)
  ) u_dec (
    .instr   (src_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      fmt_q       <= FMT_NONE;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_load) begin
      out_valid <= src_valid;
      if (src_valid) begin
        out_imm     <= dec_imm;
        fmt_q       <= dec_fmt;
        out_illegal <= dec_illegal;
      end
    end
  end

  // counts at the input handshake, so words dropped by flush are still counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (in_fire && !opc_supported(in_instr[6:0]) &&
                 illegal_cnt != {CNT_W{1'b1}}) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard testbench for imm_gen_pipe
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [7:0]  a_cnt;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [7:0]  b_cnt;

  int total = 0;
  int bad   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   occ_a = 0;
  logic flush_edge = 1'b0;
  logic a_stall_prev = 1'b0;
  logic [31:0] a_hold_imm;
  logic [2:0]  a_hold_fmt;
  logic streaming;

  logic [31:0] va_instr [8] = '{32'hFFF00093, 32'h80000063, 32'h0020006F, 32'hFE20AC23,
                                32'h123450B7, 32'h00309093, 32'h4210D093, 32'h80008067};
  logic [63:0] va_imm   [8] = '{64'hFFFFFFFF, 64'hFFFFF000, 64'h00000002, 64'hFFFFFFF8,
                                64'h12345000, 64'h00000003, 64'h00000001, 64'hFFFFF800};
  logic [2:0]  va_fmt   [8] = '{3'd1, 3'd3, 3'd5, 3'd2, 3'd4, 3'd6, 3'd6, 3'd1};

  logic [31:0] vb_instr [5] = '{32'h800000B7, 32'h4210D093, 32'hFFF00093, 32'h7FFFF017, 32'h80000063};
  logic [63:0] vb_imm   [5] = '{64'hFFFFFFFF80000000, 64'h0000000000000021, 64'hFFFFFFFFFFFFFFFF,
                                64'h000000007FFFF000, 64'hFFFFFFFFFFFFF000};
  logic [2:0]  vb_fmt   [5] = '{3'd4, 3'd6, 3'd1, 3'd4, 3'd3};

  imm_gen_pipe #(.XLEN(32), .STAGES(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // occupancy model of the 2-stage DUT, used to predict in_ready
  always @(posedge clk) begin
    flush_edge <= flush;
    if (!rst_n || flush) occ_a <= 0;
    else occ_a <= occ_a + int'(a_in_valid && a_in_ready) - int'(a_out_valid && a_out_ready);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      a_stall_prev = 1'b0;
    end else begin
      if (a_stall_prev && !flush_edge) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_imm", a_out_imm, a_hold_imm);
        chk("a_hold_fmt", a_out_fmt, a_hold_fmt);
      end
      chk("a_in_ready", a_in_ready, !(occ_a == 2 && !a_out_ready));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected: got imm %0h expected no output", a_out_imm);
        end else begin
          ea = qa.pop_front();
          chk("a_imm", a_out_imm, ea.imm[31:0]);
          chk("a_fmt", a_out_fmt, ea.fmt);
          chk("a_ill", a_out_illegal, ea.ill);
        end
      end
      a_stall_prev = a_out_valid && !a_out_ready;
      a_hold_imm   = a_out_imm;
      a_hold_fmt   = a_out_fmt;
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got imm %0h expected no output", b_out_imm);
      end else begin
        eb = qb.pop_front();
        chk("b_imm", b_out_imm, eb.imm);
        chk("b_fmt", b_out_fmt, eb.fmt);
        chk("b_ill", b_out_illegal, eb.ill);
      end
    end
  end

  task automatic send_a(input logic [31:0] instr, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_instr = instr;
    forever begin
      @(negedge clk);
      if (a_in_ready || n > 50) break;
      n++;
    end
    if (!a_in_ready) begin
      total++; bad++;
      $display("FAIL a_send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      qa.push_back('{imm, fmt, ill});
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] instr, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_instr = instr;
    forever begin
      @(negedge clk);
      if (b_in_ready || n > 50) break;
      n++;
    end
    if (!b_in_ready) begin
      total++; bad++;
      $display("FAIL b_send_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      qb.push_back('{imm, fmt, ill});
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    total++; bad++;
    $display("FAIL watchdog: got no completion expected finish before 500000ns");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    a_in_valid = 1'b0; a_in_instr = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_instr = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_imm", a_out_imm, 0);
    chk("rst_a_fmt", a_out_fmt, 0);
    chk("rst_a_ill", a_out_illegal, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_imm", b_out_imm, 0);
    rst_n = 1'b1;

    // addi -1 with 2-stage latency
    send_a(va_instr[0], va_imm[0], va_fmt[0], 1'b0);
    chk("lat_a_early", a_out_valid, 0);
    @(posedge clk); #1;
    chk("lat_a_valid", a_out_valid, 1);
    for (int i = 1; i < 8; i++) send_a(va_instr[i], va_imm[i], va_fmt[i], 1'b0);

    send_b(vb_instr[0], vb_imm[0], vb_fmt[0], 1'b0);
    chk("lat_b_valid", b_out_valid, 1);
    for (int i = 1; i < 5; i++) send_b(vb_instr[i], vb_imm[i], vb_fmt[i], 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // stream with out_ready pattern 1,0,0,1
    streaming = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_a(va_instr[i], va_imm[i], va_fmt[i], 1'b0);
        streaming = 1'b0;
      end
      begin
        int k = 0;
        while (streaming) begin
          @(posedge clk); #1;
          a_out_ready = !((k % 4) == 1 || (k % 4) == 2);
          k++;
        end
      end
    join
    a_out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stream_drain", qa.size(), 0);

    // illegal words and counter saturation
    chk("cnt_start", a_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      send_a(32'hFFFFFFFF, 64'h0, 3'd0, 1'b1);
      if (i == 253) chk("cnt_254", a_cnt, 254);
      if (i == 254) chk("cnt_255", a_cnt, 255);
    end
    chk("cnt_sat", a_cnt, 255);
    repeat (4) @(posedge clk);
    #1;

    // flush with two words in flight; b drops an illegal word during flush
    a_out_ready = 1'b0;
    send_a(va_instr[1], va_imm[1], va_fmt[1], 1'b0);
    send_a(va_instr[2], va_imm[2], va_fmt[2], 1'b0);
    flush = 1'b1;
    b_in_valid = 1'b1;
    b_in_instr = 32'hFFFFFFFF;
    @(posedge clk); #1;
    flush = 1'b0;
    b_in_valid = 1'b0;
    chk("flush_a_valid", a_out_valid, 0);
    chk("flush_b_valid", b_out_valid, 0);
    chk("flush_b_cnt", b_cnt, 1);
    qa.delete();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_a_s1_gone", a_out_valid, 0);

    // asynchronous reset mid-stream
    a_out_ready = 1'b0;
    send_a(va_instr[3], va_imm[3], va_fmt[3], 1'b0);
    send_a(va_instr[4], va_imm[4], va_fmt[4], 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", a_out_valid, 0);
    chk("arst_a_imm", a_out_imm, 0);
    chk("arst_a_fmt", a_out_fmt, 0);
    chk("arst_a_cnt", a_cnt, 0);
    chk("arst_a_ready", a_in_ready, 1);
    chk("arst_b_imm", b_out_imm, 0);
    chk("arst_b_cnt", b_cnt, 0);
    qa.delete();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_a_after", a_out_valid, 0);

    send_a(va_instr[7], va_imm[7], va_fmt[7], 1'b0);
    send_b(vb_instr[3], vb_imm[3], vb_fmt[3], 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
